digit_serial_add_sub: RTL and testbench

DIGIT_SERIAL_ADD_SUB -- requirements
Module: digit_serial_add_sub

---
 rtl/digit_serial_add_sub_if.sv | 26 ++
 rtl/digit_serial_add_sub.sv | 105 ++++++++++
 tb/tb_digit_serial_add_sub.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/digit_serial_add_sub_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
// The master drives the request and operands; the slave returns status and results.
interface digit_serial_add_sub_if #(
  parameter int WIDTH = 32
);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             SnA;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] Y;
  logic             CO;
  logic             OV;
  logic             ZERO;

  modport master (
    output START, A, B, SnA,
    input  BUSY, DONE, Y, CO, OV, ZERO
  );

  modport slave (
    input  START, A, B, SnA,
    output BUSY, DONE, Y, CO, OV, ZERO
  );
endinterface

// File: rtl/digit_serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per cycle, LSB slice first,
// results (Y/CO/OV/ZERO) published only at completion together with a one-cycle DONE.
module digit_serial_add_sub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input logic                  CLK,
  input logic                  RST,
  digit_serial_add_sub_if.slave bus
);
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               op_reg;
  logic               carry_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   y_reg;
  logic               co_reg;
  logic               ov_reg;
  logic               zero_reg;

  logic [DIGIT-1:0]   a_slice;
  logic [DIGIT-1:0]   b_slice;
  logic [DIGIT:0]     slice_full;
  logic               msb_cin;
  logic               last_slice;
  logic               accept;
  logic [WIDTH-1:0]   acc_next;

  // a_reg doubles as the accumulator: operand slices leave at the bottom while sum slices enter at the top.
  always_comb begin
    a_slice    = a_reg[DIGIT-1:0];
    b_slice    = op_reg ? ~b_reg[DIGIT-1:0] : b_reg[DIGIT-1:0];
    slice_full = {1'b0, a_slice} + {1'b0, b_slice} + {{DIGIT{1'b0}}, carry_reg};
    msb_cin    = slice_full[DIGIT-1] ^ a_slice[DIGIT-1] ^ b_slice[DIGIT-1];
    last_slice = (cnt_reg == CNT_W'(N - 1));
    accept     = bus.START && (state_reg != RUN);
  end

  generate
    if (DIGIT < WIDTH) begin : g_shift
      assign acc_next = {slice_full[DIGIT-1:0], a_reg[WIDTH-1:DIGIT]};
    end else begin : g_single
      assign acc_next = slice_full[DIGIT-1:0];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.START) state_next = RUN;
      RUN:     if (last_slice) state_next = FIN;
      FIN:     state_next = bus.START ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= 1'b0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      y_reg     <= '0;
      co_reg    <= 1'b0;
      ov_reg    <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg     <= bus.A;
        b_reg     <= bus.B;
        op_reg    <= bus.SnA;
        carry_reg <= bus.SnA;
        cnt_reg   <= '0;
      end else if (state_reg == RUN) begin
        a_reg     <= acc_next;
        b_reg     <= b_reg >> DIGIT;
        carry_reg <= slice_full[DIGIT];
        cnt_reg   <= cnt_reg + 1'b1;
        // Outputs only move on the final slice so partial sums never show.
        if (last_slice) begin
          y_reg    <= acc_next;
          co_reg   <= slice_full[DIGIT];
          ov_reg   <= slice_full[DIGIT] ^ msb_cin;
          zero_reg <= (acc_next == '0);
        end
      end
    end
  end

  assign bus.BUSY = (state_reg == RUN);
  assign bus.DONE = (state_reg == FIN);
  assign bus.Y    = y_reg;
  assign bus.CO   = co_reg;
  assign bus.OV   = ov_reg;
  assign bus.ZERO = zero_reg;
endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Self-checking bench: cycle-level arithmetic reference model compared every cycle,
// plus literal vectors, back-to-back, mid-run reset and DIGIT=1/DIGIT=32 latency checks.
module tb_digit_serial_add_sub;
  localparam int W = 32;
  localparam int D = 8;
  localparam int N = W / D;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  digit_serial_add_sub_if #(.WIDTH(W)) bus0 ();
  digit_serial_add_sub_if #(.WIDTH(W)) bus1 ();
  digit_serial_add_sub_if #(.WIDTH(W)) bus32 ();

  digit_serial_add_sub #(.WIDTH(W), .DIGIT(D)) dut0 (.CLK(clk), .RST(rst), .bus(bus0));
  digit_serial_add_sub #(.WIDTH(W), .DIGIT(1)) dut1 (.CLK(clk), .RST(rst), .bus(bus1));
  digit_serial_add_sub #(.WIDTH(W), .DIGIT(W)) dut32 (.CLK(clk), .RST(rst), .bus(bus32));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic: {carry/no-borrow, result}
  function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    if (s) return {(a >= b), a - b};
    else   return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic ref_ov(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic signed [W:0] sa, sb, r;
    sa = {a[W-1], a};
    sb = {b[W-1], b};
    r  = s ? (sa - sb) : (sa + sb);
    return r[W] != r[W-1];
  endfunction

  // Behavioural model: an accepted START completes N edges later, then one FIN cycle.
  int           rem;
  logic         fin_m;
  logic [W-1:0] ma, mb;
  logic         ms;
  logic [W-1:0] exp_y;
  logic         exp_co, exp_ov, exp_zero;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= 0; fin_m <= 1'b0; ma <= '0; mb <= '0; ms <= 1'b0;
      exp_y <= '0; exp_co <= 1'b0; exp_ov <= 1'b0; exp_zero <= 1'b0;
    end else if (rem > 0) begin
      rem   <= rem - 1;
      fin_m <= (rem == 1);
      if (rem == 1) begin
        {exp_co, exp_y} <= ref_result(ma, mb, ms);
        exp_ov          <= ref_ov(ma, mb, ms);
        exp_zero        <= (W'(ref_result(ma, mb, ms)) == '0);
      end
    end else begin
      fin_m <= 1'b0;
      if (bus0.START) begin
        ma <= bus0.A; mb <= bus0.B; ms <= bus0.SnA; rem <= N;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_busy", W'(bus0.BUSY), W'(rem != 0));
    chk("cmp_done", W'(bus0.DONE), W'(fin_m));
    chk("cmp_y",    bus0.Y,        exp_y);
    chk("cmp_co",   W'(bus0.CO),   W'(exp_co));
    chk("cmp_ov",   W'(bus0.OV),   W'(exp_ov));
    chk("cmp_zero", W'(bus0.ZERO), W'(exp_zero));
  end

  task automatic run_dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] ey, input logic eco, input logic eov, input logic ez);
    int k;
    @(negedge clk);
    bus0.START = 1'b1; bus0.A = a; bus0.B = b; bus0.SnA = s;
    for (k = 1; k <= N + 5; k++) begin
      @(negedge clk);
      if (k == 1) bus0.START = 1'b0;
      if (bus0.DONE) break;
      if (k <= N) chk("dir_busy", W'(bus0.BUSY), W'(1));
    end
    chk("dir_latency", W'(k), W'(N + 1));
    chk("dir_y", bus0.Y, ey);
    chk("dir_co", W'(bus0.CO), W'(eco));
    chk("dir_ov", W'(bus0.OV), W'(eov));
    chk("dir_zero", W'(bus0.ZERO), W'(ez));
    $display("op a=%h b=%h sna=%0d -> y=%h co=%0d ov=%0d zero=%0d", a, b, s, bus0.Y, bus0.CO, bus0.OV, bus0.ZERO);
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      4:       return W'(1);
      default: return $urandom;
    endcase
  endfunction

  logic [W-1:0] vec_a   [7] = '{32'd10, 32'd10, 32'd5, 32'd0, 32'd0, 32'h7FFFFFFF, 32'h80000000};
  logic [W-1:0] vec_b   [7] = '{32'd5, 32'd5, 32'd10, 32'd1, 32'd0, 32'd1, 32'd1};
  logic         vec_s   [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [W-1:0] vec_y   [7] = '{32'd15, 32'd5, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'd0, 32'h80000000, 32'h7FFFFFFF};
  logic         vec_co  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic         vec_ov  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic         vec_z   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int k1, k32, gap;
    bit got1, got2;
    rst = 1'b1;
    bus0.START = 1'b0; bus0.A = '0; bus0.B = '0; bus0.SnA = 1'b0;
    bus1.START = 1'b0; bus1.A = '0; bus1.B = '0; bus1.SnA = 1'b0;
    bus32.START = 1'b0; bus32.A = '0; bus32.B = '0; bus32.SnA = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(bus0.BUSY), '0);
    chk("rst_done", W'(bus0.DONE), '0);
    chk("rst_y", bus0.Y, '0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_dir(vec_a[i], vec_b[i], vec_s[i], vec_y[i], vec_co[i], vec_ov[i], vec_z[i]);

    // START held high through RUN with changing operands, then re-issued in FIN.
    @(negedge clk);
    bus0.START = 1'b1; bus0.A = 32'd10; bus0.B = 32'd5; bus0.SnA = 1'b0;
    got1 = 1'b0;
    for (int k = 1; k <= N + 5; k++) begin
      @(negedge clk);
      if (bus0.DONE) begin got1 = 1'b1; break; end
      bus0.A = $urandom; bus0.B = $urandom; bus0.SnA = 1'b1;
    end
    chk("b2b_first_done", W'(got1), W'(1));
    chk("b2b_first_y", bus0.Y, 32'd15);
    $display("b2b first y=%h", bus0.Y);
    bus0.A = 32'd3; bus0.B = 32'd4; bus0.SnA = 1'b0;
    got2 = 1'b0; gap = 0;
    for (int k = 1; k <= N + 5; k++) begin
      @(negedge clk);
      if (k == 1) bus0.START = 1'b0;
      if (bus0.DONE) begin got2 = 1'b1; gap = k; break; end
    end
    chk("b2b_gap", W'(gap), W'(N + 1));
    chk("b2b_second_y", bus0.Y, 32'd7);
    $display("b2b second y=%h gap=%0d", bus0.Y, gap);

    // Reset pulsed in the second RUN cycle, between clock edges.
    @(negedge clk);
    bus0.START = 1'b1; bus0.A = 32'd20; bus0.B = 32'd1; bus0.SnA = 1'b0;
    @(negedge clk);
    bus0.START = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", W'(bus0.BUSY), '0);
    chk("mid_rst_y", bus0.Y, '0);
    chk("mid_rst_co", W'(bus0.CO), '0);
    #1 rst = 1'b0;
    for (int k = 0; k < N + 3; k++) begin
      @(negedge clk);
      chk("mid_rst_no_done", W'(bus0.DONE), '0);
    end
    $display("mid-run reset y=%h done=%0d", bus0.Y, bus0.DONE);
    run_dir(32'd10, 32'd5, 1'b0, 32'd15, 1'b0, 1'b0, 1'b0);

    // DIGIT=1 and DIGIT=WIDTH builds.
    @(negedge clk);
    bus1.START = 1'b1; bus1.A = 32'd10; bus1.B = 32'd5; bus1.SnA = 1'b0;
    bus32.START = 1'b1; bus32.A = 32'd10; bus32.B = 32'd5; bus32.SnA = 1'b0;
    k1 = 0; k32 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin bus1.START = 1'b0; bus32.START = 1'b0; end
      if (bus1.DONE && k1 == 0) k1 = k;
      if (bus32.DONE && k32 == 0) k32 = k;
    end
    chk("d1_latency", W'(k1), W'(W + 1));
    chk("d32_latency", W'(k32), W'(2));
    chk("d1_y", bus1.Y, 32'd15);
    chk("d32_y", bus32.Y, 32'd15);
    chk("d1_co", W'(bus1.CO), '0);
    chk("d32_co", W'(bus32.CO), '0);
    $display("digit1 y=%h lat=%0d digit32 y=%h lat=%0d", bus1.Y, k1, bus32.Y, k32);

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus0.START = ($urandom_range(0, 3) != 0);
      bus0.A = rnd_op(); bus0.B = rnd_op(); bus0.SnA = 1'($urandom_range(0, 1));
      if (bus0.DONE) $display("rnd done y=%h co=%0d ov=%0d zero=%0d", bus0.Y, bus0.CO, bus0.OV, bus0.ZERO);
    end
    @(negedge clk);
    bus0.START = 1'b0;
    repeat (N + 3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
